// File: rtl/battle_pkg.sv
// Shared battle-screen constants: state encoding, battle box bounds, heart start
// position and the movement and invulnerability timing used by the heart controller.
package battle_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        IFRAME = 2'd2
    } heart_state_t;

    localparam int POS_X_W = 10;
    localparam int POS_Y_W = 9;

    localparam logic [POS_X_W-1:0] X_INIT    = 10'd310;
    localparam logic [POS_X_W-1:0] BOX_X_MIN = 10'd217;
    localparam logic [POS_X_W-1:0] BOX_X_MAX = 10'd402;
    localparam logic [POS_Y_W-1:0] Y_INIT    = 9'd290;
    localparam logic [POS_Y_W-1:0] BOX_Y_MIN = 9'd200;
    localparam logic [POS_Y_W-1:0] BOX_Y_MAX = 9'd375;

    localparam int              STEP_W = 4;
    localparam logic [STEP_W-1:0] STEP = 4'd5;

    // BLINK_FRAMES must be a power of two so one counter bit gives the blink phase
    localparam int IFRAME_FRAMES = 60;
    localparam int BLINK_FRAMES  = 4;
    localparam int IFRAME_CNT_W  = $clog2(IFRAME_FRAMES + 1);

endpackage

// File: rtl/axis_step_clamp.sv
// One axis of heart movement: steps the coordinate toward the pressed button
// and saturates the result to the battle box. Purely combinational.
module axis_step_clamp
    import battle_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [W-1:0]      cur,
    input  logic              neg_btn,
    input  logic              pos_btn,
    input  logic [STEP_W-1:0] step,
    input  logic [W-1:0]      min,
    input  logic [W-1:0]      max,
    output logic [W-1:0]      next
);

    localparam int SW = 11;

    logic signed [SW-1:0] cur_s;
    logic signed [SW-1:0] step_s;
    logic signed [SW-1:0] sum;

    // Signed arithmetic lets an overshoot below the box saturate instead of wrapping
    always_comb begin
        cur_s  = signed'(SW'(cur));
        step_s = signed'(SW'(step));
        sum    = cur_s;
        if (pos_btn && !neg_btn) begin
            sum = cur_s + step_s;
        end else if (neg_btn && !pos_btn) begin
            sum = cur_s - step_s;
        end
        if (sum < signed'(SW'(min))) begin
            next = min;
        end else if (sum > signed'(SW'(max))) begin
            next = max;
        end else begin
            next = sum[W-1:0];
        end
    end

endmodule

// File: rtl/heart_move_ctrl.sv
// Per-frame heart movement and hit/invulnerability sequencer for the battle screen.
// Optional HEART_SLOW_EN: btn_slow halves the per-frame step.
module heart_move_ctrl
    import battle_pkg::*;
(
    input  logic               Pclk,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_slow,
    input  logic               hit,
    output logic [POS_X_W-1:0] heart_x,
    output logic [POS_Y_W-1:0] heart_y,
    output logic               heart_visible,
    output logic               invuln,
    output logic               hp_dec
);

    localparam logic [IFRAME_CNT_W-1:0] IFRAME_LOAD = IFRAME_CNT_W'(IFRAME_FRAMES);
    localparam logic [IFRAME_CNT_W-1:0] BLINK_MASK  = IFRAME_CNT_W'(BLINK_FRAMES);

    heart_state_t             state, state_next;
    logic [IFRAME_CNT_W-1:0]  iframe_cnt, cnt_next;
    logic [POS_X_W-1:0]       x_next, x_stepped;
    logic [POS_Y_W-1:0]       y_next, y_stepped;
    logic                     hp_dec_next;
    logic [STEP_W-1:0]        step_cur;
    logic                     blink_off;

`ifdef HEART_SLOW_EN
    assign step_cur = btn_slow ? (STEP >> 1) : STEP;
`else
    logic slow_unused;
    assign slow_unused = btn_slow;
    assign step_cur    = STEP;
`endif

    axis_step_clamp #(.W(POS_X_W)) u_axis_x (
        .cur     (heart_x),
        .neg_btn (btn_left),
        .pos_btn (btn_right),
        .step    (step_cur),
        .min     (BOX_X_MIN),
        .max     (BOX_X_MAX),
        .next    (x_stepped)
    );

    axis_step_clamp #(.W(POS_Y_W)) u_axis_y (
        .cur     (heart_y),
        .neg_btn (btn_up),
        .pos_btn (btn_down),
        .step    (step_cur),
        .min     (BOX_Y_MIN),
        .max     (BOX_Y_MAX),
        .next    (y_stepped)
    );

    always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            iframe_cnt <= '0;
            heart_x    <= X_INIT;
            heart_y    <= Y_INIT;
            hp_dec     <= 1'b0;
        end else begin
            state      <= state_next;
            iframe_cnt <= cnt_next;
            heart_x    <= x_next;
            heart_y    <= y_next;
            hp_dec     <= hp_dec_next;
        end
    end

    // Dropping enable overrides everything, including a hit in the same cycle
    always_comb begin
        state_next  = state;
        cnt_next    = iframe_cnt;
        x_next      = heart_x;
        y_next      = heart_y;
        hp_dec_next = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
            x_next     = X_INIT;
            y_next     = Y_INIT;
        end else begin
            case (state)
                IDLE: begin
                    state_next = MOVE;
                    x_next     = X_INIT;
                    y_next     = Y_INIT;
                end
                MOVE: begin
                    if (frame_tick) begin
                        x_next = x_stepped;
                        y_next = y_stepped;
                    end
                    if (hit) begin
                        hp_dec_next = 1'b1;
                        cnt_next    = IFRAME_LOAD;
                        state_next  = IFRAME;
                    end
                end
                IFRAME: begin
                    if (frame_tick) begin
                        x_next   = x_stepped;
                        y_next   = y_stepped;
                        cnt_next = iframe_cnt - 1'b1;
                        if (iframe_cnt == IFRAME_CNT_W'(1)) begin
                            state_next = MOVE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Blink phase is taken from frames elapsed so the first half-period is visible
    assign blink_off     = |((IFRAME_LOAD - iframe_cnt) & BLINK_MASK);
    assign invuln        = (state == IFRAME);
    assign heart_visible = (state == MOVE) || ((state == IFRAME) && !blink_off);

endmodule

// File: tb/tb_heart_move_ctrl.sv
// Self-checking bench for heart_move_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a frame-level reference model.
module tb_heart_move_ctrl;

    logic       Pclk = 1'b0;
    logic       rst;
    logic       enable, frame_tick, hit;
    logic       btn_up, btn_down, btn_left, btn_right, btn_slow;
    logic [9:0] heart_x;
    logic [8:0] heart_y;
    logic       heart_visible, invuln, hp_dec;

    int tests  = 0;
    int failed = 0;

    // Reference model kept as plain integers: position, frames of invulnerability left
    bit m_on;
    int m_x, m_y, m_left;
    bit m_hp;

    typedef struct {
        logic en, tick, up, down, left, right, hit;
        int   ex, ey;
        logic evis, einv, ehp;
    } vec_t;

    vec_t tbl[11];

    heart_move_ctrl dut (
        .Pclk          (Pclk),
        .rst           (rst),
        .enable        (enable),
        .frame_tick    (frame_tick),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_slow      (btn_slow),
        .hit           (hit),
        .heart_x       (heart_x),
        .heart_y       (heart_y),
        .heart_visible (heart_visible),
        .invuln        (invuln),
        .hp_dec        (hp_dec)
    );

    always #5 Pclk = ~Pclk;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_x = 310; m_y = 290; m_left = 0; m_hp = 0;
    endtask

    task automatic model_step();
        int  st;
        bit  was_inv;
        st = 5;
`ifdef HEART_SLOW_EN
        if (btn_slow) st = 2;
`endif
        if (!enable) begin
            model_reset();
        end else if (!m_on) begin
            m_on = 1;
            m_hp = 0;
        end else begin
            was_inv = (m_left > 0);
            m_hp = 0;
            if (frame_tick) begin
                m_x = clampi(m_x + (int'(btn_right) - int'(btn_left)) * st, 217, 402);
                m_y = clampi(m_y + (int'(btn_down) - int'(btn_up)) * st, 200, 375);
            end
            if (!was_inv && hit) begin
                m_hp = 1;
                m_left = 60;
            end else if (was_inv && frame_tick) begin
                m_left--;
            end
        end
    endtask

    task automatic check_model(input string tag);
        bit vis;
        vis = m_on && (m_left == 0 || (((60 - m_left) / 4) % 2) == 0);
        check({tag, ".x"}, 32'(heart_x), 32'(m_x));
        check({tag, ".y"}, 32'(heart_y), 32'(m_y));
        check({tag, ".vis"}, 32'(heart_visible), 32'(vis));
        check({tag, ".inv"}, 32'(invuln), 32'(m_left > 0));
        check({tag, ".hp"}, 32'(hp_dec), 32'(m_hp));
    endtask

    task automatic drive_and_clock(input logic en, input logic tick, input logic up,
                                   input logic down, input logic left, input logic right,
                                   input logic slow, input logic h);
        enable = en; frame_tick = tick; btn_up = up; btn_down = down;
        btn_left = left; btn_right = right; btn_slow = slow; hit = h;
        @(posedge Pclk);
        model_step();
        @(negedge Pclk);
    endtask

    task automatic applyStimulus(input logic en, input logic tick, input logic up,
                                 input logic down, input logic left, input logic right,
                                 input logic slow, input logic h);
        drive_and_clock(en, tick, up, down, left, right, slow, h);
        check_model("model");
    endtask

    // One video frame: a tick cycle followed by three mid-frame cycles
    task automatic frame(input logic up, input logic down, input logic left,
                         input logic right, input logic slow, input logic hit_tick);
        applyStimulus(1, 1, up, down, left, right, slow, hit_tick);
        repeat (3) applyStimulus(1, 0, up, down, left, right, slow, 0);
    endtask

    task automatic checkOutput(input string name, input int ex, input int ey,
                               input logic evis, input logic einv, input logic ehp);
        check({name, ".x"}, 32'(heart_x), 32'(ex));
        check({name, ".y"}, 32'(heart_y), 32'(ey));
        check({name, ".vis"}, 32'(heart_visible), 32'(evis));
        check({name, ".inv"}, 32'(invuln), 32'(einv));
        check({name, ".hp"}, 32'(hp_dec), 32'(ehp));
    endtask

    task automatic do_reset();
        rst = 1;
        enable = 0; frame_tick = 0; hit = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_slow = 0;
        repeat (2) @(negedge Pclk);
        model_reset();
        checkOutput("reset", 310, 290, 0, 0, 0);
        rst = 0;
    endtask

    initial begin
        //              en tick up dn lf rt hit   x    y  vis inv hp
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 310, 290, 1, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 1, 0, 315, 290, 1, 0, 0};
        tbl[2]  = '{1, 0, 1, 1, 1, 0, 0, 315, 290, 1, 0, 0};
        tbl[3]  = '{1, 1, 1, 1, 1, 0, 0, 310, 290, 1, 0, 0};
        tbl[4]  = '{1, 1, 0, 1, 0, 1, 0, 315, 295, 1, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 1, 315, 295, 1, 1, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 315, 295, 1, 1, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 1, 315, 295, 1, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 310, 290, 0, 0, 0};
        tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 310, 290, 1, 0, 0};
        tbl[10] = '{1, 1, 1, 0, 1, 1, 0, 310, 285, 1, 0, 0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive_and_clock(tbl[i].en, tbl[i].tick, tbl[i].up, tbl[i].down,
                            tbl[i].left, tbl[i].right, 1'b0, tbl[i].hit);
            checkOutput($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey,
                        tbl[i].evis, tbl[i].einv, tbl[i].ehp);
        end

        // Right held for 30 frames saturates at the right wall
        do_reset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("enable", 310, 290, 1, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            frame(0, 0, 0, 1, 0, 0);
            check($sformatf("sat_x%0d", k), 32'(heart_x), 32'((310 + 5 * k > 402) ? 402 : 310 + 5 * k));
        end
        check("sat_y", 32'(heart_y), 32'd290);

        // Hit in MOVE, second hit ignored, 4-on/4-off blink, return to MOVE after 60 ticks
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("hit", 402, 290, 1, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        check("hit_once", 32'(hp_dec), 32'd0);
        for (int k = 1; k <= 60; k++) begin
            frame(0, 0, 0, 0, 0, (k == 10));
            if (k == 4)  check("blink_off4", 32'(heart_visible), 32'd0);
            if (k == 8)  check("blink_on8", 32'(heart_visible), 32'd1);
            if (k == 59) check("inv59", 32'(invuln), 32'd1);
        end
        checkOutput("iframe_end", 402, 290, 1, 0, 0);

        // Hit and tick together with down held at the bottom wall
        for (int k = 0; k < 17; k++) frame(0, 1, 0, 0, 0, 0);
        check("bottom", 32'(heart_y), 32'd375);
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 1);
        checkOutput("hit_tick", 402, 375, 1, 1, 1);
        repeat (3) applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 60; k++) begin
            frame(0, 0, 0, 0, 0, 0);
            if (k == 59) check("ht_inv59", 32'(invuln), 32'd1);
            if (k == 60) check("ht_inv60", 32'(invuln), 32'd0);
        end

        // Enable dropped mid-IFRAME at (250, 210)
        do_reset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) frame(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) frame(1, 0, 0, 0, 0, 0);
        check("corner_x", 32'(heart_x), 32'd250);
        check("corner_y", 32'(heart_y), 32'd210);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        frame(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drop", 310, 290, 0, 0, 0);

        // Hit with enable low: no hp_dec
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("hit_disabled", 310, 290, 0, 0, 0);

        // Slow button: halved step only when the feature is built in
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        frame(0, 0, 0, 1, 1, 0);
`ifdef HEART_SLOW_EN
        check("slow_x", 32'(heart_x), 32'd312);
`else
        check("slow_x", 32'(heart_x), 32'd315);
`endif

        // Asynchronous reset asserted mid-IFRAME, between clock edges
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        frame(0, 1, 0, 0, 0, 0);
        @(posedge Pclk);
        #2 rst = 1;
        enable = 0; hit = 0; frame_tick = 0; btn_down = 0;
        #1;
        model_reset();
        checkOutput("async_rst", 310, 290, 0, 0, 0);
        @(negedge Pclk);
        rst = 0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic en, tk, h;
            logic [4:0] b;
            en = ($urandom_range(0, 149) != 0);
            tk = ((c % 6) == 0);
            h  = ($urandom_range(0, 24) == 0);
            b  = 5'($urandom);
            applyStimulus(en, tk, b[0], b[1], b[2], b[3], b[4], h);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
